// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative restoring integer divider (DIV/DIVU) with start/busy/done handshake
// Signed operation is built in only when ALU_DIV_SIGNED_EN is defined; otherwise every operation is unsigned.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             dz,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic             take;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             unused_bits;

    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
        a_neg = sign & a[WIDTH-1];
        b_neg = sign & b[WIDTH-1];
`endif
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

`ifdef ALU_DIV_SIGNED_EN
    assign unused_bits = rem[WIDTH];
`else
    assign unused_bits = rem[WIDTH] ^ sign;
`endif

    // One restoring step: shift the next dividend bit into the partial remainder and try the subtract.
    always_comb begin
        shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        take     = (shifted >= {1'b0, dvs});
        rem_next = take ? (shifted - {1'b0, dvs}) : shifted;
        quo_next = {quo[WIDTH-2:0], take};
        q_fix    = neg_q ? -quo_next : quo_next;
        r_fix    = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    assign z = (q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            q     <= '1;
                            r     <= a;
                            dz    <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            dz    <= 1'b0;
                            busy  <= 1'b1;
                            count <= CW'(WIDTH);
                            rem   <= '0;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        q     <= q_fix;
                        r     <= r_fix;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// tb/tb_alu_divider.sv - self-checking bench for alu_divider against a plain-arithmetic model
module tb_alu_divider;

    localparam int W = 32;
`ifdef ALU_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sign  = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    logic         dz;
    logic         busy;
    logic         done;

    alu_divider #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .sign (sign),
        .a    (a),
        .b    (b),
        .q    (q),
        .r    (r),
        .z    (z),
        .dz   (dz),
        .busy (busy),
        .done (done)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                      output logic [W-1:0] mq, output logic [W-1:0] mr,
                                      output logic mdz);
        bit     eff;
        longint sx;
        longint sy;
        eff = s && SIGNED_EN;
        if (y == '0) begin
            mq  = '1;
            mr  = x;
            mdz = 1'b1;
        end else if (eff) begin
            sx  = $signed(x);
            sy  = $signed(y);
            mq  = W'(sx / sy);
            mr  = W'(sx % sy);
            mdz = 1'b0;
        end else begin
            mq  = x / y;
            mr  = x % y;
            mdz = 1'b0;
        end
    endfunction

    // Model: an accepted op finishes W edges later (same edge for divide-by-zero); idle again one cycle after done.
    int           e        = 0;
    int           done_at  = -10;
    bit           active   = 1'b0;
    logic [W-1:0] pq, pr;
    logic         pdz;
    logic [W-1:0] mq_o     = '0;
    logic [W-1:0] mr_o     = '0;
    logic         mdz_o    = 1'b0;
    bit           exp_busy = 1'b0;
    bit           exp_done = 1'b0;
    int           accepts  = 0;
    int           aborts   = 0;

    always @(posedge clock) begin
        e++;
        if (reset) begin
            if (active && e <= done_at) aborts++;
            active   = 1'b0;
            mq_o     = '0;
            mr_o     = '0;
            mdz_o    = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (start && (!active || e > done_at + 1)) begin
                active = 1'b1;
                model_div(a, b, sign, pq, pr, pdz);
                done_at = e + (pdz ? 0 : W);
                accepts++;
                if (!pdz) mdz_o = 1'b0;
            end
            exp_busy = active && (e < done_at);
            exp_done = active && (e == done_at);
            if (exp_done) begin
                mq_o  = pq;
                mr_o  = pr;
                mdz_o = pdz;
            end
        end
    end

    bit chk_en    = 1'b0;
    int dut_dones = 0;

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("q", q, mq_o);
            check("r", r, mr_o);
            check("dz", dz, mdz_o);
            check("z", z, (mq_o == '0));
            if (done) dut_dones++;
        end
    end

    // mode 0: quiet; mode 1: random ignored starts while busy/done; mode 2: starts at cycles 5 and 20
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int mode,
                          output int lat, output bit saw_busy);
        a = x;
        b = y;
        sign = s;
        start = 1'b1;
        saw_busy = 1'b0;
        lat = 0;
        @(negedge clock);
        lat = 1;
        start = 1'b0;
        while (1) begin
            if (busy) saw_busy = 1'b1;
            if (done || lat >= W + 10) break;
            if (mode == 1) start = ($urandom_range(3) == 0);
            else if (mode == 2) start = (lat == 5 || lat == 20);
            else start = 1'b0;
            a = $urandom;
            b = (mode == 2) ? 32'd1 : $urandom;
            sign = $urandom_range(1);
            @(negedge clock);
            lat++;
        end
        check("done_within_bound", done, 1'b1);
        start = (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
    endtask

    task automatic directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                            input int mode, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic edz, input int elat);
        int lat;
        bit sb;
        run_op(x, y, s, mode, lat, sb);
        check({nm, "_lat"}, lat, elat);
        check({nm, "_q"}, q, eq);
        check({nm, "_r"}, r, er);
        check({nm, "_dz"}, dz, edz);
        check({nm, "_z"}, z, (eq == '0));
        if (edz) check({nm, "_busy_seen"}, sb, 1'b0);
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] tq, tr;
        logic         tdz;
        int           lat;
        int           cnt;
        bit           sb;
        logic [W-1:0] ra, rb;

        model_div(32'd100, 32'd7, 1'b0, tq, tr, tdz);
        check("model_100_7_q", tq, 32'd14);
        check("model_100_7_r", tr, 32'd2);
        model_div(32'hFFFFFFF9, 32'd2, 1'b1, tq, tr, tdz);
        check("model_m7_2_q", tq, SIGNED_EN ? 32'hFFFFFFFD : 32'h7FFFFFFC);
        check("model_m7_2_r", tr, SIGNED_EN ? 32'hFFFFFFFF : 32'd1);
        model_div(32'h80000000, 32'hFFFFFFFF, 1'b1, tq, tr, tdz);
        check("model_ovf_q", tq, SIGNED_EN ? 32'h80000000 : 32'd0);
        check("model_ovf_r", tr, SIGNED_EN ? 32'd0 : 32'h80000000);
        model_div(32'h1234, 32'd0, 1'b0, tq, tr, tdz);
        check("model_dz", {tq, tr}, {32'hFFFFFFFF, 32'h1234});

        @(negedge clock);
        @(negedge clock);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_z", z, 1'b1);
        check("rst_dz", dz, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);

        directed("udiv", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0, W + 1);
        directed("sdiv", 32'hFFFFFFF9, 32'd2, 1'b1, 0,
                 SIGNED_EN ? 32'hFFFFFFFD : 32'h7FFFFFFC, SIGNED_EN ? 32'hFFFFFFFF : 32'd1, 1'b0, W + 1);
        directed("sdiv_u", 32'hFFFFFFF9, 32'd2, 1'b0, 0, 32'h7FFFFFFC, 32'd1, 1'b0, W + 1);
        directed("divz", 32'h1234, 32'd0, 1'b0, 0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1);
        directed("small", 32'd5, 32'd9, 1'b0, 0, 32'd0, 32'd5, 1'b0, W + 1);
        directed("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 0,
                 SIGNED_EN ? 32'h80000000 : 32'd0, SIGNED_EN ? 32'd0 : 32'h80000000, 1'b0, W + 1);
        directed("ignore", 32'd100, 32'd7, 1'b0, 2, 32'd14, 32'd2, 1'b0, W + 1);
        directed("b2b", 32'd1000, 32'd10, 1'b0, 0, 32'd100, 32'd0, 1'b0, W + 1);

        // Abort: reset sampled at the end of cycle 10 of an operation.
        a = 32'd12345;
        b = 32'd11;
        sign = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_q", q, 32'd0);
        check("abort_r", r, 32'd0);
        check("abort_z", z, 1'b1);
        cnt = 0;
        repeat (W + 5) begin
            @(negedge clock);
            if (done) cnt++;
        end
        check("abort_no_done", cnt, 0);
        directed("after_abort", 32'd12345, 32'd11, 1'b0, 0, 32'd1122, 32'd3, 1'b0, W + 1);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(7) == 0) ? 32'h80000000 : $urandom;
            if ($urandom_range(3) == 0) ra = 32'($urandom_range(0, 20));
            model_div(ra, rb, 1'b0, tq, tr, tdz);
            run_op(ra, rb, 1'($urandom_range(1)), 1, lat, sb);
            check("rand_lat", lat, tdz ? 1 : W + 1);
            @(negedge clock);
            start = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("done_count", dut_dones, accepts - aborts);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
